// File: rtl/strum_event_encoder_pkg.sv
// Shared constants for the strum event encoder: source IDs, event byte layout
// and polarity values, plus a helper that packs one event byte.
package strum_pkg;

    typedef enum logic [1:0] {
        SRC_GREEN = 2'd0,
        SRC_BLUE  = 2'd1,
        SRC_FOOT  = 2'd2
    } src_e;

    localparam int NUM_SRC   = 3;
    localparam int EV_W      = 8;
    localparam int SEQ_W     = 5;

    localparam int EV_POL    = 7;
    localparam int EV_SRC_HI = 6;
    localparam int EV_SRC_LO = 5;
    localparam int EV_SEQ_HI = 4;

    localparam logic POL_PRESS   = 1'b1;
    localparam logic POL_RELEASE = 1'b0;

    function automatic logic [EV_W-1:0] make_event(
        input logic             pol,
        input logic [1:0]       src,
        input logic [SEQ_W-1:0] seq
    );
        logic [EV_W-1:0] ev;
        ev                       = '0;
        ev[EV_POL]               = pol;
        ev[EV_SRC_HI:EV_SRC_LO]  = src;
        ev[EV_SEQ_HI:0]          = seq;
        return ev;
    endfunction

endpackage

// File: rtl/strum_event_encoder_if.sv
// Valid/ready event stream between the encoder and the host-link serializer.
interface strum_event_encoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/strum_event_encoder_event_fifo.sv
// Synchronous FIFO with a registered head: a pushed entry reaches the head
// register one cycle after it is written into the ring.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      ring_count;
    logic             head_valid;
    logic             do_pop;
    logic             do_push;
    logic             load;

    // empty tracks the head register, so it lags a push into an empty FIFO
    assign empty   = !head_valid;
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && head_valid;
    assign do_push = push && (!full || do_pop);
    assign load    = (ring_count != '0) && (!head_valid || do_pop);

    // NOTE: storage is deliberately left out of reset; pointers and counts
    // alone define which entries are live, and plain RAM maps better.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ring_count <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                head       <= mem[rd_ptr];
                head_valid <= 1'b1;
                rd_ptr     <= rd_ptr + AW'(1);
            end else if (do_pop) begin
                head_valid <= 1'b0;
            end
            ring_count <= ring_count + (AW+1)'(do_push) - (AW+1)'(load);
            count      <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/strum_event_encoder.sv
// Turns debounced strum/foot levels into timestamped press/release bytes with
// per-source press holdoff, one pending slot per source and an output FIFO.
module strum_event_encoder
    import strum_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int HOLDOFF    = 2500000,
    parameter int HO_W       = 22
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          strum_g,
    input  logic                          strum_b,
    input  logic                          drum_foot,
    input  logic                          ovf_clr,
    strum_event_encoder_if.master         ev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam logic [HO_W-1:0] HOLDOFF_LD = HO_W'(HOLDOFF);

    logic [NUM_SRC-1:0] level;
    logic [NUM_SRC-1:0] hist;
    logic [HO_W-1:0]    holdoff_ctr [NUM_SRC];
    logic [NUM_SRC-1:0] suppress;
    logic [NUM_SRC-1:0] slot_full;
    logic [NUM_SRC-1:0] slot_pol;
    logic [SEQ_W-1:0]   seq;

    logic [NUM_SRC-1:0] edge_ok, edge_pol, ho_load, sup_set, sup_clr, drop;
    logic [NUM_SRC-1:0] grant;
    logic               push;
    logic [EV_W-1:0]    push_data;
    logic               pop;
    logic               can_push;
    logic               fifo_full;
    logic               fifo_empty;

    always_comb begin
        level            = '0;
        level[SRC_GREEN] = strum_g;
        level[SRC_BLUE]  = strum_b;
        level[SRC_FOOT]  = drum_foot;
    end

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave a value unassigned and infer a latch.
    always_comb begin
        edge_ok  = '0;
        edge_pol = '0;
        ho_load  = '0;
        sup_set  = '0;
        sup_clr  = '0;
        drop     = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (level[s] && !hist[s]) begin
                edge_pol[s] = POL_PRESS;
                if (holdoff_ctr[s] == '0) begin
                    ho_load[s] = 1'b1;
                    edge_ok[s] = 1'b1;
                end else begin
                    sup_set[s] = 1'b1;
                end
            end else if (!level[s] && hist[s]) begin
                edge_pol[s] = POL_RELEASE;
                if (suppress[s]) sup_clr[s] = 1'b1;
                else             edge_ok[s] = 1'b1;
            end
            drop[s] = edge_ok[s] && slot_full[s];
        end
    end

    // Fixed priority: lowest source index wins the single write per cycle
    assign pop      = ev.ev_valid && ev.ev_ready;
    assign can_push = !fifo_full || pop;

    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (can_push && slot_full[s] && !push) begin
                grant[s]  = 1'b1;
                push      = 1'b1;
                push_data = make_event(slot_pol[s], 2'(s), seq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            suppress  <= '0;
            slot_full <= '0;
            slot_pol  <= '0;
            seq       <= '0;
            overflow  <= 1'b0;
            for (int s = 0; s < NUM_SRC; s++) holdoff_ctr[s] <= '0;
        end else begin
            hist <= level;
            if (push)         seq      <= seq + SEQ_W'(1);
            if (|drop)        overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (edge_ok[s] && !slot_full[s]) begin
                    slot_full[s] <= 1'b1;
                    slot_pol[s]  <= edge_pol[s];
                end else if (grant[s]) begin
                    slot_full[s] <= 1'b0;
                end
                if (sup_set[s])      suppress[s] <= 1'b1;
                else if (sup_clr[s]) suppress[s] <= 1'b0;
                if (ho_load[s])                holdoff_ctr[s] <= HOLDOFF_LD;
                else if (holdoff_ctr[s] != '0) holdoff_ctr[s] <= holdoff_ctr[s] - HO_W'(1);
            end
        end
    end

    event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (ev.ev_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (ev.ev_data),
        .count     (fifo_count)
    );

    assign ev.ev_valid = !fifo_empty;

endmodule

// File: doc/strum_event_encoder.md
Name: strum_event_encoder

Overview:
- Sits directly downstream of the instrument debouncer. Consumes its debounced level outputs: green strum, blue strum and drum foot.
- Converts level changes into timestamped press/release event bytes and filters rapid re-presses with a per-source holdoff.
- Buffers events in a small FIFO and presents them on a valid/ready stream to the host-link serializer.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- HOLDOFF, 2500000, minimum cycles between accepted presses on one source (50 ms at 50 MHz).
- HO_W, 22, holdoff counter width; must satisfy 2^HO_W > HOLDOFF.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- strum_g  in  1  debounced green strum level.
- strum_b  in  1  debounced blue strum level.
- drum_foot  in  1  debounced foot pedal level.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ovf_clr  in  1  clears the overflow flag.
- ev_valid  out  1  head event available.
- ev_data  out  8  event byte.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky flag: an event was lost.

Behaviour:
- Reset:
  - Outputs: ev_valid=0, ev_data=0, fifo_count=0, overflow=0.
  - Internal state: input history registers load 0; pending slots empty; holdoff counters 0; sequence counter 0; suppress flags 0.
- Edge detect: each source has a history register. A rise (in=1, hist=0) is a press; a fall (in=0, hist=1) is a release.
- Event byte:
  - [7]: 1=press, 0=release.
  - [6:5]: source; 0=green, 1=blue, 2=foot; 3 is never emitted.
  - [4:0]: sequence number, a 5-bit counter incremented on every FIFO write; wraps 31->0.
- Holdoff:
  - An accepted press loads that source's counter with HOLDOFF. The counter decrements to 0.
  - A press while the counter is nonzero is discarded and sets that source's suppress flag.
  - The next release on that source is discarded and clears the flag. Suppressed edges never touch overflow.
  - Releases never load the counter.
- Pending slots: one per source; holds polarity. A detected, non-suppressed edge sets the slot.
  - If the slot is already occupied, the new edge is dropped and overflow is set.
- Arbiter: at most one FIFO write per cycle, fixed priority green > blue > foot. A slot clears on the cycle it is written.
  - FIFO full: no write; slots keep their contents.
- Latency:
  - Input change sampled at edge k -> pending at k.
  - With an empty FIFO and no contention -> write at k+1, ev_valid=1 after k+2.
  - Worst-case arbitration adds 2 cycles.
- FIFO:
  - Head is registered. ev_valid && ev_ready pops the head.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Pop when empty is ignored.
  - ev_data is held stable while ev_valid && !ev_ready.
- Overflow:
  - ovf_clr clears it; a new drop in the same cycle wins (flag stays 1).
  - Overflow does not block operation.
- Reset mid-operation: FIFO and pending slots are flushed; in-flight events are lost and not counted as overflow. History registers reload 0, so an input held high at reset release produces a press the following cycle.

Decomposition:
- Shared package strum_pkg holds:
  - Source IDs: SRC_GREEN=0, SRC_BLUE=1, SRC_FOOT=2.
  - Event field positions: EV_POL=7, EV_SRC_HI=6, EV_SRC_LO=5, EV_SEQ_HI=4.
  - Polarity constants: POL_PRESS=1, POL_RELEASE=0.
- Sub-module event_fifo: a synchronous FIFO with registered head, count output, and push/pop/full/empty. Parameters are WIDTH=8 and DEPTH=FIFO_DEPTH.
- Edge detect, holdoff and arbiter stay in the top module.

Test Plan:
- Single press: HOLDOFF=8. Raise strum_g at cycle 10, hold ev_ready=1 -> ev_valid rises two cycles later with ev_data=0x80. Lower at cycle 30 -> 0x01 (release, green, seq 1).
- Simultaneous press: all three inputs rise on the same cycle with ev_ready=1 -> three events on consecutive cycles: 0x80, 0xA1, 0xC2.
- Holdoff: HOLDOFF=8. Press blue at t=0, release t=3, press t=5, release t=7, press t=20 -> events 0xA0, 0x21, 0xA2. The t=5/t=7 pair is suppressed and overflow stays 0.
- Backpressure and overflow: FIFO_DEPTH=4, ev_ready=0. Issue 5 alternating green edges ≥4 cycles apart -> fifo_count=4 and 4 events are held. The 5th edge sits in its pending slot; a 6th edge sets overflow=1. Then raise ev_ready -> heads drain in order with seq 0..4, and ev_data stays stable while stalled.
- Sequence wrap: generate 33 foot edges -> the 33rd event has seq 0, ev_data bits [4:0]=0.
- Reset mid-stream: fill 3 entries, then assert rst one cycle with drum_foot held 1 -> fifo_count=0 and overflow=0. The next event is 0xC0.
